hwpe_job_launcher: RTL and testbench
====================================

Name: hwpe_job_launcher

Overview:
- Master-side counterpart of the HWPE peripheral slave. It drives the periph request channel to program and start one accelerator job at a time.
- Per accepted job: acquire a context, write N_PARAMS job registers, trigger, wait for completion, report the job ID upstream.
- Sits between a local job-command queue (or a small core) and the MAC/HWPE control port, replacing software register programming.

Parameters:
- N_PARAMS, 8, number of job-dependent registers written per job (1..16)
- ID, 10, width of periph_id_o / periph_r_id_i
- BASE_ADDR, 32'h0, HWPE register-space base
- BACKOFF_CYC, 16, idle cycles between failed ACQUIRE attempts (>=1)
- LAUNCHER_ID, 0, constant driven on periph_id_o

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- job_valid_i  in  1  job command valid
- job_ready_o  out  1  job command accepted
- job_params_i  in  N_PARAMS*32  register values; index i goes to offset 0x40+4*i
- done_valid_o  out  1  completion valid
- done_ready_i  in  1  completion accepted
- done_job_id_o  out  8  job ID returned by ACQUIRE
- busy_o  out  1  high whenever not IDLE
- evt_i  in  1  HWPE end-of-job event for this core, single-cycle pulse
- periph_req_o  out  1  request
- periph_gnt_i  in  1  grant
- periph_add_o  out  32  byte address
- periph_wen_o  out  1  1 = read, 0 = write
- periph_be_o  out  4  byte enables, always 4'hF
- periph_data_o  out  32  write data
- periph_id_o  out  ID  transaction ID
- periph_r_valid_i  in  1  response valid
- periph_r_data_i  in  32  read data

Behaviour:
- Reset: all outputs 0 (periph_be_o = 4'hF, periph_id_o = LAUNCHER_ID). State returns to IDLE. Param buffer, counters and event flag are cleared. Reset mid-transaction drops req immediately; any late r_valid is ignored in IDLE.
- Protocol:
  - At most one outstanding transaction.
  - req/add/wen/data are held stable from assertion until the gnt cycle. req deasserts the cycle after gnt.
  - Every transaction, read or write, completes on a later r_valid (>= 1 cycle after gnt). The next request is issued the cycle after r_valid, never earlier.
- Register offsets: TRIGGER 0x00, ACQUIRE 0x04, STATUS 0x0C, PARAM 0x40.
- FSM:
  - IDLE: job_ready_o = 1. On job_valid_i, latch job_params_i and go to ACQ.
  - ACQ: read ACQUIRE.
    - On r_valid with r_data[31] = 1 (busy, -1): go to BACKOFF.
    - Otherwise: latch r_data[7:0] as the job ID, clear the event flag, set the param counter to 0, go to WRP.
  - BACKOFF: count BACKOFF_CYC cycles, then go to ACQ.
  - WRP: write param[cnt] to PARAM + 4*cnt. On r_valid, cnt++. When cnt == N_PARAMS-1 completes, go to TRIG.
  - TRIG: write 0 to TRIGGER. On r_valid, go to WAIT.
  - WAIT: when the event flag is set, go to DONE.
  - DONE: done_valid_o = 1 holding the job ID. On done_ready_i, go to IDLE.
- Event flag: sticky, set by evt_i in any state except IDLE. This covers an evt_i pulse arriving in the same cycle as the TRIGGER r_valid. Clearing on ACQ success takes priority over a simultaneous set.
- Counter widths: param counter $clog2(N_PARAMS+1); backoff counter $clog2(BACKOFF_CYC+1). Address arithmetic is modulo 2^32.
- Throughput: back-to-back jobs are allowed. IDLE accepts a new job the cycle after the DONE handshake.

Optional Feature:
- HWPE_LAUNCHER_POLL_EN defined: evt_i is ignored. WAIT issues STATUS reads continuously, each following the previous r_valid. It exits to DONE on the first response with r_data == 0.
- Not defined: WAIT issues no periph traffic and waits for the event flag only.

Decomposition:
- Shared package hwpe_launcher_package:
  - register offset constants (TRIGGER/ACQUIRE/STATUS/PARAM)
  - FSM state enum launcher_state_t
  - a periph master request struct (req/add/wen/be/data/id)
- One sub-module, hwpe_periph_master_port: single-outstanding request/response sequencer. It takes a command (addr, wen, data) with valid/ready and returns rsp valid+data. The FSM sits above it.

Test Plan:
- Single job, N_PARAMS = 2, gnt same cycle, r_valid +1, ACQUIRE returns 3:
  - writes 0x40 and 0x44, then 0x00, in order;
  - evt_i pulse gives done_job_id_o = 3;
  - busy_o falls after done_ready_i.
- ACQUIRE returns 32'hFFFFFFFF twice, then 1: exactly 3 ACQUIRE reads, each retry separated by >= BACKOFF_CYC idle cycles; job ID 1 reported.
- Grant stall (gnt low 5 cycles) on a write: add/data/wen stable all 5 cycles; no second req before r_valid.
- evt_i asserted in the same cycle as TRIGGER r_valid: DONE is still reached. A stale evt_i during IDLE does not complete the next job.
- rst_i asserted in WRP after the first param write: next cycle req = 0 and state is IDLE. A late r_valid is ignored. The next job restarts from ACQUIRE.
- With HWPE_LAUNCHER_POLL_EN, STATUS reads return 1, 1, 0: 3 STATUS reads, then done_valid_o; evt_i toggling has no effect.

Source files
------------

// File: rtl/hwpe_job_launcher_pkg.sv
// Shared types and constants for the HWPE job launcher.
// Register offsets, FSM encodings and periph request bundle.
package hwpe_launcher_package;

  localparam logic [31:0] REG_TRIGGER = 32'h00;
  localparam logic [31:0] REG_ACQUIRE = 32'h04;
  localparam logic [31:0] REG_STATUS  = 32'h0C;
  localparam logic [31:0] REG_PARAM   = 32'h40;

  typedef logic [2:0] launcher_state_t;

  localparam launcher_state_t S_IDLE    = 3'd0;
  localparam launcher_state_t S_ACQ     = 3'd1;
  localparam launcher_state_t S_BACKOFF = 3'd2;
  localparam launcher_state_t S_WRP     = 3'd3;
  localparam launcher_state_t S_TRIG    = 3'd4;
  localparam launcher_state_t S_WAIT    = 3'd5;
  localparam launcher_state_t S_DONE    = 3'd6;

  localparam int unsigned MAX_ID_W = 32;

  typedef struct packed {
    logic                req;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [MAX_ID_W-1:0] id;
  } periph_req_t;

  function automatic logic [31:0] param_addr(
    input logic [31:0] base,
    input logic [4:0]  idx
  );
    return base + REG_PARAM + {25'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/hwpe_job_launcher_if.sv
// Periph request/response channel between launcher and HWPE.
// Master drives req/add/wen/be/data/id, slave answers gnt/r_*.
interface hwpe_job_launcher_if #(
  parameter int unsigned ID = 10
) ();

  logic          periph_req_o;
  logic          periph_gnt_i;
  logic [31:0]   periph_add_o;
  logic          periph_wen_o;
  logic [3:0]    periph_be_o;
  logic [31:0]   periph_data_o;
  logic [ID-1:0] periph_id_o;
  logic          periph_r_valid_i;
  logic [31:0]   periph_r_data_i;

  modport master (
    output periph_req_o,
    output periph_add_o,
    output periph_wen_o,
    output periph_be_o,
    output periph_data_o,
    output periph_id_o,
    input  periph_gnt_i,
    input  periph_r_valid_i,
    input  periph_r_data_i
  );

  modport slave (
    input  periph_req_o,
    input  periph_add_o,
    input  periph_wen_o,
    input  periph_be_o,
    input  periph_data_o,
    input  periph_id_o,
    output periph_gnt_i,
    output periph_r_valid_i,
    output periph_r_data_i
  );

endinterface

// File: rtl/hwpe_job_launcher_port.sv
// Single-outstanding periph master sequencer.
// A command is presented until granted; then r_valid is awaited.
module hwpe_periph_master_port
  import hwpe_launcher_package::*;
#(
  parameter int unsigned ID          = 10,
  parameter int unsigned LAUNCHER_ID = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic        cmd_wen_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  hwpe_job_launcher_if.master periph
);

  logic        wait_q;
  logic        wait_d;
  periph_req_t req_s;

  // Track whether a granted transaction awaits its response
  always_comb begin
    wait_d = wait_q;
    if (!wait_q && cmd_valid_i && periph.periph_gnt_i) begin
      wait_d = 1'b1;
    end else if (wait_q && periph.periph_r_valid_i) begin
      wait_d = 1'b0;
    end
  end

  // Request is driven straight from the command while idle
  always_comb begin
    req_s      = '0;
    req_s.be   = 4'hF;
    req_s.id   = MAX_ID_W'(LAUNCHER_ID);
    if (!wait_q && cmd_valid_i && !rst_i) begin
      req_s.req  = 1'b1;
      req_s.add  = cmd_addr_i;
      req_s.wen  = cmd_wen_i;
      req_s.data = cmd_data_i;
    end
  end

  // Outstanding-transaction flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign periph.periph_req_o  = req_s.req;
  assign periph.periph_add_o  = req_s.add;
  assign periph.periph_wen_o  = req_s.wen;
  assign periph.periph_be_o   = req_s.be;
  assign periph.periph_data_o = req_s.data;
  assign periph.periph_id_o   = req_s.id[ID-1:0];

  assign cmd_ready_o = !wait_q && periph.periph_gnt_i;
  assign rsp_valid_o = wait_q && periph.periph_r_valid_i;
  assign rsp_data_o  = periph.periph_r_data_i;

endmodule

// File: rtl/hwpe_job_launcher.sv
// HWPE job launcher: acquire, program, trigger, wait, report.
// HWPE_LAUNCHER_POLL_EN: poll STATUS instead of using evt_i.
module hwpe_job_launcher
  import hwpe_launcher_package::*;
#(
  parameter int unsigned N_PARAMS    = 8,
  parameter int unsigned ID          = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned BACKOFF_CYC = 16,
  parameter int unsigned LAUNCHER_ID = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [N_PARAMS*32-1:0] job_params_i,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output logic [7:0]            done_job_id_o,
  output logic                  busy_o,
  input  logic                  evt_i,
  hwpe_job_launcher_if.master   periph
);

  localparam int unsigned CW = $clog2(N_PARAMS + 1);
  localparam int unsigned BW = $clog2(BACKOFF_CYC + 1);

  launcher_state_t state_q, state_d;
  logic [N_PARAMS-1:0][31:0] params_q, params_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] boff_q, boff_d;
  logic [7:0]    job_id_q, job_id_d;
  logic          evt_q, evt_d;
  logic          infl_q, infl_d;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_wen;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp;

  hwpe_periph_master_port #(
    .ID          (ID),
    .LAUNCHER_ID (LAUNCHER_ID)
  ) i_port (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_wen_i   (cmd_wen),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .periph      (periph)
  );

  assign rsp = rsp_valid && infl_q;

  // Command issued by each bus-active state
  always_comb begin
    cmd_valid = 1'b0;
    cmd_wen   = 1'b1;
    cmd_addr  = BASE_ADDR + REG_ACQUIRE;
    cmd_data  = '0;
    unique case (state_q)
      S_ACQ: begin
        cmd_valid = 1'b1;
      end
      S_WRP: begin
        cmd_valid = 1'b1;
        cmd_wen   = 1'b0;
        cmd_addr  = param_addr(BASE_ADDR, 5'(cnt_q));
        for (int i = 0; i < N_PARAMS; i++) begin
          if (cnt_q == CW'(i)) cmd_data = params_q[i];
        end
      end
      S_TRIG: begin
        cmd_valid = 1'b1;
        cmd_wen   = 1'b0;
        cmd_addr  = BASE_ADDR + REG_TRIGGER;
      end
`ifdef HWPE_LAUNCHER_POLL_EN
      S_WAIT: begin
        cmd_valid = 1'b1;
        cmd_addr  = BASE_ADDR + REG_STATUS;
      end
`endif
      default: ;
    endcase
  end

  // Job sequencing FSM and its datapath
  always_comb begin
    state_d  = state_q;
    params_d = params_q;
    cnt_d    = cnt_q;
    boff_d   = boff_q;
    job_id_d = job_id_q;
    evt_d    = evt_q;
    infl_d   = infl_q;
    if (rsp) begin
      infl_d = 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      infl_d = 1'b1;
    end
`ifndef HWPE_LAUNCHER_POLL_EN
    if (state_q != S_IDLE && evt_i) evt_d = 1'b1;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (job_valid_i) begin
          params_d = job_params_i;
          state_d  = S_ACQ;
        end
      end
      S_ACQ: begin
        if (rsp) begin
          if (rsp_data[31]) begin
            boff_d  = '0;
            state_d = S_BACKOFF;
          end else begin
            job_id_d = rsp_data[7:0];
            evt_d    = 1'b0;
            cnt_d    = '0;
            state_d  = S_WRP;
          end
        end
      end
      S_BACKOFF: begin
        if (boff_q == BW'(BACKOFF_CYC - 1)) begin
          state_d = S_ACQ;
        end else begin
          boff_d = boff_q + 1'b1;
        end
      end
      S_WRP: begin
        if (rsp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N_PARAMS - 1)) state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (rsp) state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef HWPE_LAUNCHER_POLL_EN
        if (rsp && rsp_data == 32'h0) state_d = S_DONE;
`else
        if (evt_q) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        if (done_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      params_q <= '0;
      cnt_q    <= '0;
      boff_q   <= '0;
      job_id_q <= '0;
      evt_q    <= 1'b0;
      infl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      params_q <= params_d;
      cnt_q    <= cnt_d;
      boff_q   <= boff_d;
      job_id_q <= job_id_d;
      evt_q    <= evt_d;
      infl_q   <= infl_d;
    end
  end

`ifdef HWPE_LAUNCHER_POLL_EN
  logic unused_evt;
  assign unused_evt = evt_i;
`else
  logic unused_rsp_bits;
  assign unused_rsp_bits = ^rsp_data[30:8];
`endif

  assign job_ready_o   = (state_q == S_IDLE) && !rst_i;
  assign busy_o        = (state_q != S_IDLE);
  assign done_valid_o  = (state_q == S_DONE);
  assign done_job_id_o = job_id_q;

endmodule

// File: tb/tb_hwpe_job_launcher.sv
// Directed bench for hwpe_job_launcher with a periph slave model.
// Build with HWPE_LAUNCHER_POLL_EN to cover the polling variant.
module tb_hwpe_job_launcher;
  import hwpe_launcher_package::*;

  localparam int NP  = 2;
  localparam int BO  = 4;
  localparam int LID = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic job_valid = 1'b0;
  logic [NP*32-1:0] job_params = '0;
  logic done_ready = 1'b0;
  logic evt = 1'b0;
  logic job_ready, done_valid, busy;
  logic [7:0] done_id;

  hwpe_job_launcher_if #(.ID(10)) pif ();

  hwpe_job_launcher #(
    .N_PARAMS    (NP),
    .ID          (10),
    .BASE_ADDR   (32'h0),
    .BACKOFF_CYC (BO),
    .LAUNCHER_ID (LID)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .job_valid_i   (job_valid),
    .job_ready_o   (job_ready),
    .job_params_i  (job_params),
    .done_valid_o  (done_valid),
    .done_ready_i  (done_ready),
    .done_job_id_o (done_id),
    .busy_o        (busy),
    .evt_i         (evt),
    .periph        (pif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] log_add[$];
  logic [31:0] log_data[$];
  logic        log_wen[$];
  int          log_cyc[$];
  logic [31:0] acq_q[$];
  logic [31:0] stat_q[$];

  logic        pending = 1'b0;
  int          dcnt = 0;
  int          next_lat = 1;
  logic [31:0] lat_addr = 32'hFFFF_FFFF;
  int          lat_val = 1;
  logic [31:0] pend_data = '0;
  logic [31:0] pend_add = '0;
  logic        pend_wen = 1'b0;
  logic        evt_pulse = 1'b0;
  logic        evt_on_trig = 1'b0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          stab_err = 0;
  int          proto_err = 0;
  logic        stalling = 1'b0;
  logic [31:0] cap_add, cap_data;
  logic        cap_wen;

  // Periph slave: immediate grant unless stalled, response latency
  initial begin
    pif.periph_gnt_i     = 1'b0;
    pif.periph_r_valid_i = 1'b0;
    pif.periph_r_data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      pif.periph_r_valid_i = 1'b0;
      evt = 1'b0;
      if (evt_pulse) begin
        evt = 1'b1;
        evt_pulse = 1'b0;
      end
      if (pif.periph_gnt_i) begin
        pending = 1'b1;
        dcnt = next_lat;
      end
      pif.periph_gnt_i = 1'b0;
      if (pending) begin
        dcnt--;
        if (dcnt == 0) begin
          pending = 1'b0;
          pif.periph_r_valid_i = 1'b1;
          pif.periph_r_data_i  = pend_data;
          if (evt_on_trig && pend_add == 32'h0
              && !pend_wen) begin
            evt = 1'b1;
            evt_on_trig = 1'b0;
          end
        end
      end
      if (pif.periph_req_o) begin
        if (pending || pif.periph_r_valid_i) begin
          proto_err++;
        end else if (stall_left > 0 &&
                     pif.periph_add_o == stall_addr) begin
          if (!stalling) begin
            cap_add  = pif.periph_add_o;
            cap_data = pif.periph_data_o;
            cap_wen  = pif.periph_wen_o;
          end else if (cap_add !== pif.periph_add_o ||
                       cap_data !== pif.periph_data_o ||
                       cap_wen !== pif.periph_wen_o) begin
            stab_err++;
          end
          stalling = 1'b1;
          stall_left--;
          stall_seen++;
        end else begin
          if (stalling && (cap_add !== pif.periph_add_o ||
              cap_data !== pif.periph_data_o ||
              cap_wen !== pif.periph_wen_o)) stab_err++;
          stalling = 1'b0;
          pif.periph_gnt_i = 1'b1;
          log_add.push_back(pif.periph_add_o);
          log_data.push_back(pif.periph_data_o);
          log_wen.push_back(pif.periph_wen_o);
          log_cyc.push_back(cyc);
          pend_add = pif.periph_add_o;
          pend_wen = pif.periph_wen_o;
          next_lat = (pif.periph_add_o == lat_addr)
                     ? lat_val : 1;
          pend_data = '0;
          if (pif.periph_wen_o && pif.periph_add_o == 32'h4)
            pend_data = (acq_q.size() > 0)
                        ? acq_q.pop_front() : 32'h0;
          if (pif.periph_wen_o && pif.periph_add_o == 32'hC)
            pend_data = (stat_q.size() > 0)
                        ? stat_q.pop_front() : 32'h0;
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (log_add.size() < n && k < 300) begin
      tick(1);
      k++;
    end
    chk("wait_log", 32'(log_add.size() >= n), 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done_valid && k < 300) begin
      tick(1);
      k++;
    end
    chk("wait_done", 32'(done_valid), 1);
  endtask

  task automatic pulse_evt();
    evt_pulse = 1'b1;
    tick(2);
  endtask

  task automatic start_job(input logic [31:0] p0,
                           input logic [31:0] p1);
    job_params = {p1, p0};
    job_valid = 1'b1;
    tick(1);
    job_valid = 1'b0;
  endtask

  task automatic finish_job();
    done_ready = 1'b1;
    tick(1);
    done_ready = 1'b0;
    chk("busy_after_done", 32'(busy), 0);
    chk("done_valid_after", 32'(done_valid), 0);
  endtask

  function automatic int count_addr(input int from,
                                    input logic [31:0] a);
    int c = 0;
    for (int i = from; i < log_add.size(); i++)
      if (log_add[i] == a) c++;
    return c;
  endfunction

  int s;
  int s2;

  initial begin
    rst = 1'b1;
    tick(3);
    chk("rst_req", 32'(pif.periph_req_o), 0);
    chk("rst_job_ready", 32'(job_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_be", 32'(pif.periph_be_o), 32'hF);
    chk("rst_id", 32'(pif.periph_id_o), LID);
    chk("rst_job_id", 32'(done_id), 0);
    rst = 1'b0;
    tick(1);
    chk("idle_job_ready", 32'(job_ready), 1);

    // single job, ACQUIRE returns 3
    acq_q.push_back(32'h3);
    start_job(32'hA0A0_0001, 32'hB0B0_0002);
    chk("t1_busy", 32'(busy), 1);
    wait_log(4);
    tick(3);
`ifndef HWPE_LAUNCHER_POLL_EN
    chk("t1_no_early_done", 32'(done_valid), 0);
    pulse_evt();
`endif
    wait_done();
    chk("t1_job_id", 32'(done_id), 3);
    chk("t1_acq_add", log_add[0], 32'h04);
    chk("t1_acq_wen", 32'(log_wen[0]), 1);
    chk("t1_p0_add", log_add[1], 32'h40);
    chk("t1_p0_data", log_data[1], 32'hA0A0_0001);
    chk("t1_p0_wen", 32'(log_wen[1]), 0);
    chk("t1_p1_add", log_add[2], 32'h44);
    chk("t1_p1_data", log_data[2], 32'hB0B0_0002);
    chk("t1_trig_add", log_add[3], 32'h00);
    chk("t1_trig_data", log_data[3], 32'h0);
    chk("t1_trig_wen", 32'(log_wen[3]), 0);
    chk("t1_busy_in_done", 32'(busy), 1);
    finish_job();

    // ACQUIRE busy twice, then ID 1
    s = log_add.size();
    acq_q.push_back(32'hFFFF_FFFF);
    acq_q.push_back(32'hFFFF_FFFF);
    acq_q.push_back(32'h1);
    start_job(32'h11, 32'h22);
    wait_log(s + 6);
    tick(3);
`ifndef HWPE_LAUNCHER_POLL_EN
    pulse_evt();
`endif
    wait_done();
    chk("t2_job_id", 32'(done_id), 1);
    chk("t2_acq_reads", count_addr(s, 32'h4), 3);
    chk("t2_gap1",
        32'(log_cyc[s+1] - log_cyc[s] - 2 >= BO), 1);
    chk("t2_gap2",
        32'(log_cyc[s+2] - log_cyc[s+1] - 2 >= BO), 1);
    chk("t2_p0_add", log_add[s+3], 32'h40);
    finish_job();

    // grant stall on the second param write
    s = log_add.size();
    acq_q.push_back(32'h7);
    stall_seen = 0;
    stall_addr = 32'h44;
    stall_left = 5;
    start_job(32'hC0DE_0000, 32'hDEAD_BEEF);
    wait_log(s + 4);
    tick(3);
`ifndef HWPE_LAUNCHER_POLL_EN
    pulse_evt();
`endif
    wait_done();
    chk("t3_job_id", 32'(done_id), 7);
    chk("t3_stall_cycles", stall_seen, 5);
    chk("t3_stable", stab_err, 0);
    chk("t3_single_outst", proto_err, 0);
    chk("t3_p1_data", log_data[s+2], 32'hDEAD_BEEF);
    finish_job();

`ifndef HWPE_LAUNCHER_POLL_EN
    // evt coincident with TRIGGER r_valid
    acq_q.push_back(32'h8);
    evt_on_trig = 1'b1;
    start_job(32'h1, 32'h2);
    wait_done();
    chk("t4_job_id", 32'(done_id), 8);
    chk("t4_evt_fired", 32'(evt_on_trig), 0);
    finish_job();

    // stale evt in IDLE must not complete next job
    pulse_evt();
    s = log_add.size();
    acq_q.push_back(32'h9);
    start_job(32'h3, 32'h4);
    wait_log(s + 4);
    tick(4);
    chk("t4_stale_evt", 32'(done_valid), 0);
    pulse_evt();
    wait_done();
    chk("t4b_job_id", 32'(done_id), 9);
    finish_job();
`endif

    // reset during WRP with a late response pending
    s = log_add.size();
    acq_q.push_back(32'h2);
    lat_addr = 32'h44;
    lat_val = 4;
    start_job(32'h55, 32'h66);
    wait_log(s + 3);
    rst = 1'b1;
    tick(1);
    chk("t5_req_drop", 32'(pif.periph_req_o), 0);
    chk("t5_idle", 32'(busy), 0);
    rst = 1'b0;
    tick(6);
    lat_addr = 32'hFFFF_FFFF;
    chk("t5_late_rsp_busy", 32'(busy), 0);
    chk("t5_late_rsp_done", 32'(done_valid), 0);
    chk("t5_no_traffic", log_add.size(), s + 3);
    chk("t5_ready", 32'(job_ready), 1);
    s2 = log_add.size();
    acq_q.push_back(32'h4);
    start_job(32'h77, 32'h88);
    wait_log(s2 + 1);
    chk("t5_restart_acq", log_add[s2], 32'h04);
    wait_log(s2 + 4);
    tick(3);
`ifndef HWPE_LAUNCHER_POLL_EN
    pulse_evt();
`endif
    wait_done();
    chk("t5_job_id", 32'(done_id), 4);
    chk("t5_p0_data", log_data[s2+1], 32'h77);
    finish_job();

`ifdef HWPE_LAUNCHER_POLL_EN
    // STATUS polled until it reads 0; evt ignored
    s = log_add.size();
    acq_q.push_back(32'h5);
    stat_q.push_back(32'h1);
    stat_q.push_back(32'h1);
    stat_q.push_back(32'h0);
    start_job(32'h9, 32'hA);
    pulse_evt();
    pulse_evt();
    pulse_evt();
    wait_done();
    chk("t6_job_id", 32'(done_id), 5);
    chk("t6_status_reads", count_addr(s, 32'hC), 3);
    finish_job();
`endif

    chk("final_proto", proto_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
